// File: rtl/ad_rd_pkg.sv
// Shared types and constants for the A/D half-buffer read master.
// AD_RD_CHECKSUM_EN adds a checksum trailer word to every block.
package ad_rd_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
`ifdef AD_RD_CHECKSUM_EN
        , ST_TRAIL
`endif
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } skid_word_t;

    // Number of stream words emitted per block.
    function automatic int blk_len(input int words);
`ifdef AD_RD_CHECKSUM_EN
        return words + 1;
`else
        return words;
`endif
    endfunction

endpackage

// File: rtl/ad_rd_skid.sv
// Two-entry in-order valid/ready skid buffer carrying data, sop and eop.
module ad_rd_skid
    import ad_rd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_vld,
    input  skid_word_t in_word,
    output logic       in_rdy,
    output logic [1:0] cnt,
    output logic       out_vld,
    output skid_word_t out_word,
    input  logic       out_rdy
);

    skid_word_t ent_q [2];
    logic       wp_q;
    logic       rp_q;
    logic [1:0] cnt_q;
    logic       pop;

    assign pop = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (in_vld) begin
                ent_q[wp_q] <= in_word;
                wp_q        <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            cnt_q <= cnt_q + {1'b0, in_vld} - {1'b0, pop};
        end
    end

    // Head entry is a register, so the output holds until it is popped.
    assign out_vld  = (cnt_q != 2'd0);
    assign out_word = ent_q[rp_q];
    assign in_rdy   = (cnt_q != 2'd2);
    assign cnt      = cnt_q;

endmodule

// File: rtl/ad_rd_master.sv
// Reads one half of the A/D ping-pong buffer per request and streams it out.
// AD_RD_CHECKSUM_EN appends a mod-2^32 sum of the block as a trailer word.
module ad_rd_master
    import ad_rd_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int BASE0 = 0,
    parameter int BASE1 = 1024
) (
    input  logic              rdclk,
    input  logic              rst_n,
    input  logic              buf_rdy,
    input  logic              buf_sel,
    output logic [ADDR_W-1:0] addr,
    output logic              cs_n,
    output logic              rd,
    input  logic [DATA_W-1:0] a2do,
    input  logic              waitreq,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic              busy,
    output logic              ovf
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, idx_q;
    logic              pend_q, pend_sel_q, ovf_q;
    logic              start, start_sel, push, drained;
    skid_word_t        push_w, sk_out;
    logic              sk_rdy;
    logic [1:0]        sk_cnt;
`ifdef AD_RD_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
`endif

    // Skid is empty once the word now on the output leaves.
    assign drained = (sk_cnt == 2'd0) || (sk_cnt == 2'd1 && dout_valid && dout_ready);

    always_comb begin
        state_d     = state_q;
        rd          = 1'b0;
        push        = 1'b0;
        start       = 1'b0;
        start_sel   = buf_sel;
        push_w.data = a2do;
        push_w.sop  = (idx_q == '0);
        push_w.eop  = ({{(32-ADDR_W){1'b0}}, idx_q} + 32'd1 == 32'(blk_len(WORDS)));
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    start     = 1'b1;
                    start_sel = pend_sel_q;
                end else if (buf_rdy) begin
                    start = 1'b1;
                end
                if (start) state_d = ST_READ;
            end
            ST_READ: begin
                rd = sk_rdy;
                if (sk_rdy && !waitreq) begin
                    push = 1'b1;
                    if (idx_q == ADDR_W'(WORDS - 1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
`ifdef AD_RD_CHECKSUM_EN
                    state_d     = ST_TRAIL;
                    push        = 1'b1;
                    push_w.data = sum_q;
                    push_w.sop  = 1'b0;
                    push_w.eop  = 1'b1;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef AD_RD_CHECKSUM_EN
            ST_TRAIL: begin
                if (drained) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge rdclk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            pend_sel_q <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef AD_RD_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            ovf_q   <= buf_rdy && pend_q && (state_q != ST_IDLE);
            // A pending request leaves in IDLE; a same-cycle buf_rdy takes its slot.
            if (state_q == ST_IDLE) begin
                if (pend_q) begin
                    pend_q     <= buf_rdy;
                    pend_sel_q <= buf_sel;
                end
            end else if (buf_rdy && !pend_q) begin
                pend_q     <= 1'b1;
                pend_sel_q <= buf_sel;
            end
            if (start) begin
                base_q <= start_sel ? ADDR_W'(BASE1) : ADDR_W'(BASE0);
                idx_q  <= '0;
`ifdef AD_RD_CHECKSUM_EN
                sum_q  <= '0;
`endif
            end else if (rd && !waitreq) begin
                idx_q <= idx_q + 1'b1;
`ifdef AD_RD_CHECKSUM_EN
                sum_q <= sum_q + a2do;
`endif
            end
        end
    end

    ad_rd_skid u_skid (
        .clk      (rdclk),
        .rst_n    (rst_n),
        .in_vld   (push),
        .in_word  (push_w),
        .in_rdy   (sk_rdy),
        .cnt      (sk_cnt),
        .out_vld  (dout_valid),
        .out_word (sk_out),
        .out_rdy  (dout_ready)
    );

    assign addr     = base_q + idx_q;
    assign cs_n     = ~rd;
    assign dout     = sk_out.data;
    assign dout_sop = sk_out.sop;
    assign dout_eop = sk_out.eop;
    assign busy     = (state_q != ST_IDLE);
    assign ovf      = ovf_q;

endmodule
